bip_cpu_ws: RTL
===============

Name: bip_cpu_ws

Overview:
Parametrised successor to the accumulator CPU. It combines the control and datapath into one core and adds conditional and unconditional branches, a HALT state, and a data-memory wait-state handshake (i_DmReady). It also adds a retired-instruction counter. It sits between the program memory, which is combinational (instruction valid in the same cycle as the address), and a data memory or bus that may stall.

Parameters:
NBITS_O, 11, operand / address width (program and data memory).
NBITS_D, 16, data and accumulator width.
OPCODE, 5, opcode width. Instruction width is OPCODE+NBITS_O, with the opcode in the MSBs.
NBITS_CNT, 16, retired-instruction counter width.

Ports:
i_clk  in  1  clock, all state on the rising edge.
i_reset  in  1  synchronous reset, active-high.
i_Instruction  in  OPCODE+NBITS_O  instruction at o_PmAddr, same cycle.
i_OutData  in  NBITS_D  data-memory read data, valid when i_DmReady=1.
i_DmReady  in  1  data-memory completes the current o_Rd/o_Wr request this cycle.
o_PmAddr  out  NBITS_O  program counter.
o_DmAddr  out  NBITS_O  data-memory address (instruction operand).
o_Rd  out  1  read request.
o_Wr  out  1  write request.
o_InData  out  NBITS_D  write data (ACC).
o_Halted  out  1  core is in HALT.
o_InstrCnt  out  NBITS_CNT  retired instructions, wraps.

Behaviour:
- One clock domain (i_clk). Reset is synchronous and active-high (i_reset).
- Reset (takes priority over everything, including in WAIT): PC=0, ACC=0, state=RUN, o_Halted=0, o_InstrCnt=0, latched request cleared. o_Rd=o_Wr=0 in the cycle after reset is sampled.
- ISA (opcode values):
  - 00000 HLT.
  - 00001 STO: mem[op]=ACC.
  - 00010 LD: ACC=mem[op].
  - 00011 LDI: ACC=sext(op).
  - 00100 ADD: ACC+=mem[op].
  - 00101 ADDI: ACC+=sext(op).
  - 00110 SUB: ACC-=mem[op].
  - 00111 SUBI: ACC-=sext(op).
  - 01000 BEQ: if ACC==0, PC=op.
  - 01001 BNE: if ACC!=0, PC=op.
  - 01010 BRA: PC=op.
  - All other opcodes: NOP.
- Arithmetic: the operand is sign-extended to NBITS_D for immediates. Add/sub wrap modulo 2^NBITS_D; no flags stored.
- PC increments modulo 2^NBITS_O, so 0x7FF+1 wraps to 0x000. A branch target is the operand unmodified.
- FSM states: RUN, WAIT, HALT.
  - RUN, non-memory instruction: executes in 1 cycle. ACC/PC update at the clock edge, o_InstrCnt+1.
  - RUN, memory instruction (STO/LD/ADD/SUB): o_Rd or o_Wr is asserted combinationally from the decode in the same cycle, with o_DmAddr=op and o_InData=ACC.
    - If i_DmReady=1 that cycle: complete (ACC/PC/count update) and stay in RUN.
    - Otherwise: latch opcode and operand, go to WAIT.
  - WAIT: o_Rd/o_Wr, o_DmAddr and o_InData come from the latch and are held stable. PC, ACC and count are frozen. i_Instruction is ignored. On i_DmReady=1: complete (i_OutData sampled that cycle for LD/ADD/SUB), PC+1, go to RUN.
  - HLT in RUN: go to HALT. PC is not incremented; HLT counts as retired (+1).
  - HALT: o_Halted=1, no requests, PC/ACC/count frozen. Exit only by reset.
- Outside RUN/WAIT memory cycles: o_Rd=o_Wr=0 and o_DmAddr=operand of the current instruction. o_InData always equals ACC, except in a WAIT store, where it is the latched ACC (identical in value, since ACC is frozen).
- i_DmReady is ignored when no request is active.
- o_Rd and o_Wr are never asserted together.
- Latency: 1 cycle per instruction, plus the number of wait cycles for memory ops.

Decomposition:
- Package bip_pkg holds:
  - the opcode localparams (OP_HLT … OP_BRA);
  - the FSM state encoding (ST_RUN, ST_WAIT, ST_HALT);
  - a sign-extension function.
- One sub-module, bip_datapath_ws, contains ACC, the immediate/memory operand mux and the add/sub unit. Its inputs are i_SelA, i_SelB, i_WrAcc and i_Op, driven by the FSM in bip_cpu_ws.
- PC, FSM, request latch and counter stay in the top.

Test Plan:
1. Reset, then program LDI 5; ADDI 0x7FE; STO 3 with i_DmReady tied 1 → ACC=0x0003; STO cycle shows o_Wr=1, o_DmAddr=3, o_InData=0x0003; PC=3; o_InstrCnt=3.
2. LD 10 with i_DmReady low for 3 cycles, then high with i_OutData=0x1234 → o_Rd=1 with o_DmAddr=10 stable for 4 cycles, PC held at the LD address, then ACC=0x1234 and PC+1; count +1 only once.
3. Branches:
   - ACC=0, BEQ 0x040 → PC=0x040.
   - ACC=1, BEQ 0x040 → PC+1.
   - ACC=1, BNE 0x020 → PC=0x020.
   - BRA 0x7FF, then NOP at 0x7FF → PC wraps to 0x000.
4. Wrap arithmetic, 16-bit:
   - ACC=0x7FFF, ADDI 1 → 0x8000.
   - ACC=0, SUBI 1 → 0xFFFF.
   - LDI 0x400 → ACC=0xFC00.
5. HLT at PC 7 → o_Halted=1, PC stays 7, count frozen; 10 further cycles show no o_Rd/o_Wr; reset → o_Halted=0, PC=0.
6. Reset asserted during WAIT of STO → next cycle o_Wr=0, PC=0, ACC=0, state RUN; a late i_DmReady pulse has no effect.

Source files
------------

// File: rtl/bip_pkg.sv
// Shared definitions for the wait-state accumulator core: opcodes, FSM states
// and an operand sign-extension helper.
package bip_pkg;

    localparam logic [4:0] OP_HLT  = 5'b00000;
    localparam logic [4:0] OP_STO  = 5'b00001;
    localparam logic [4:0] OP_LD   = 5'b00010;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SUBI = 5'b00111;
    localparam logic [4:0] OP_BEQ  = 5'b01000;
    localparam logic [4:0] OP_BNE  = 5'b01001;
    localparam logic [4:0] OP_BRA  = 5'b01010;

    typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_HALT} state_t;

    // Sign-extend the low w bits of v to 32 bits; callers truncate to their width.
    function automatic logic [31:0] sext32(input logic [31:0] v, input int unsigned w);
        return 32'($signed(v << (32 - w)) >>> (32 - w));
    endfunction

endpackage

// File: rtl/bip_if.sv
// Program-memory and data-memory bus seen by the core; master is the CPU side.
interface bip_if #(
    parameter int NBITS_O   = 11,
    parameter int NBITS_D   = 16,
    parameter int OPCODE    = 5,
    parameter int NBITS_CNT = 16
);
    logic [OPCODE+NBITS_O-1:0] i_Instruction;
    logic [NBITS_D-1:0]        i_OutData;
    logic                      i_DmReady;
    logic [NBITS_O-1:0]        o_PmAddr;
    logic [NBITS_O-1:0]        o_DmAddr;
    logic                      o_Rd;
    logic                      o_Wr;
    logic [NBITS_D-1:0]        o_InData;
    logic                      o_Halted;
    logic [NBITS_CNT-1:0]      o_InstrCnt;

    modport master (
        input  i_Instruction, i_OutData, i_DmReady,
        output o_PmAddr, o_DmAddr, o_Rd, o_Wr, o_InData, o_Halted, o_InstrCnt
    );
    modport slave (
        output i_Instruction, i_OutData, i_DmReady,
        input  o_PmAddr, o_DmAddr, o_Rd, o_Wr, o_InData, o_Halted, o_InstrCnt
    );
endinterface

// File: rtl/bip_datapath_ws.sv
// Accumulator datapath: operand mux (immediate vs memory), add/sub unit and ACC.
module bip_datapath_ws
    import bip_pkg::*;
#(
    parameter int NBITS_O = 11,
    parameter int NBITS_D = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_SelA,    // 1: ACC <= ALU result, 0: ACC <= operand
    input  logic               i_SelB,    // 1: sign-extended immediate, 0: memory data
    input  logic               i_WrAcc,
    input  logic               i_Op,      // 1: subtract
    input  logic [NBITS_O-1:0] i_Operand,
    input  logic [NBITS_D-1:0] i_MemData,
    output logic [NBITS_D-1:0] o_Acc
);
    logic [NBITS_D-1:0] acc_q, acc_d, opnd, alu;

    always_comb begin
        opnd  = i_SelB ? NBITS_D'(sext32(32'(i_Operand), NBITS_O)) : i_MemData;
        alu   = i_Op ? acc_q - opnd : acc_q + opnd;
        acc_d = acc_q;
        if (i_WrAcc) acc_d = i_SelA ? alu : opnd;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) acc_q <= '0;
        else         acc_q <= acc_d;
    end

    assign o_Acc = acc_q;
endmodule

// File: rtl/bip_cpu_ws.sv
// Accumulator CPU core with branches, HALT and a data-memory wait-state
// handshake; PC, FSM, request latch and retired-instruction counter live here.
module bip_cpu_ws
    import bip_pkg::*;
#(
    parameter int NBITS_O   = 11,
    parameter int NBITS_D   = 16,
    parameter int OPCODE    = 5,
    parameter int NBITS_CNT = 16
) (
    input  logic i_clk,
    input  logic i_reset,
    bip_if.master bus
);
    state_t               state_q, state_d;
    logic [NBITS_O-1:0]   pc_q, pc_d;
    logic [NBITS_CNT-1:0] cnt_q, cnt_d;
    logic [OPCODE-1:0]    lat_op_q, lat_op_d;
    logic [NBITS_O-1:0]   lat_opd_q, lat_opd_d;

    logic [OPCODE-1:0]    op;
    logic [NBITS_O-1:0]   opd;
    logic                 in_wait, is_rd, is_wr, req, done;
    logic                 sel_a, sel_b, wr_acc, alu_sub;
    logic [NBITS_D-1:0]   acc;

    always_comb begin
        in_wait = (state_q == ST_WAIT);
        // In WAIT the request is replayed from the latch; the fetch bus is ignored.
        op      = in_wait ? lat_op_q  : bus.i_Instruction[OPCODE+NBITS_O-1:NBITS_O];
        opd     = in_wait ? lat_opd_q : bus.i_Instruction[NBITS_O-1:0];
        is_rd   = (op == OP_LD) || (op == OP_ADD) || (op == OP_SUB);
        is_wr   = (op == OP_STO);
        req     = (state_q != ST_HALT) && (is_rd || is_wr) && !i_reset;
        done    = req ? bus.i_DmReady : (state_q == ST_RUN);

        sel_b   = (op == OP_LDI) || (op == OP_ADDI) || (op == OP_SUBI);
        sel_a   = (op == OP_ADD) || (op == OP_ADDI) || (op == OP_SUB) || (op == OP_SUBI);
        alu_sub = (op == OP_SUB) || (op == OP_SUBI);
        wr_acc  = 1'b0;

        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        lat_op_d  = lat_op_q;
        lat_opd_d = lat_opd_q;

        if (done) begin
            cnt_d   = cnt_q + 1'b1;
            wr_acc  = sel_a || (op == OP_LD) || (op == OP_LDI);
            state_d = ST_RUN;
            pc_d    = pc_q + 1'b1;
            case (op)
                OP_HLT: begin
                    pc_d    = pc_q;
                    state_d = ST_HALT;
                end
                OP_BEQ:  if (acc == '0) pc_d = opd;
                OP_BNE:  if (acc != '0) pc_d = opd;
                OP_BRA:  pc_d = opd;
                default: ;
            endcase
        end else if (req && state_q == ST_RUN) begin
            state_d   = ST_WAIT;
            lat_op_d  = op;
            lat_opd_d = opd;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= ST_RUN;
            pc_q      <= '0;
            cnt_q     <= '0;
            lat_op_q  <= '0;
            lat_opd_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            lat_op_q  <= lat_op_d;
            lat_opd_q <= lat_opd_d;
        end
    end

    bip_datapath_ws #(.NBITS_O(NBITS_O), .NBITS_D(NBITS_D)) u_dp (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_SelA    (sel_a),
        .i_SelB    (sel_b),
        .i_WrAcc   (wr_acc),
        .i_Op      (alu_sub),
        .i_Operand (opd),
        .i_MemData (bus.i_OutData),
        .o_Acc     (acc)
    );

    assign bus.o_PmAddr   = pc_q;
    assign bus.o_DmAddr   = opd;
    assign bus.o_Rd       = req && is_rd;
    assign bus.o_Wr       = req && is_wr;
    assign bus.o_InData   = acc;
    assign bus.o_Halted   = (state_q == ST_HALT);
    assign bus.o_InstrCnt = cnt_q;
endmodule
